// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - MEM pipeline stage: branch resolve, req/gnt/rvalid data port, MEM/WB register.
// Optional feature macro: MEM_MISALIGN_TRAP_EN (misaligned accesses retire without a request).
module mem_stage #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] pc_plus_4_i,
  input  logic [31:0] ex_result_i,
  input  logic        zero_flag_i,
  input  logic [31:0] reg2_data_i,
  input  logic [31:0] immediate_i,
  input  logic [4:0]  rd_addr_i,
  input  logic [2:0]  funct3_i,
  input  logic        mem_read_i,
  input  logic        mem_write_i,
  input  logic        branch_ctrl_i,
  input  logic        reg_write_i,
  input  logic [1:0]  mem_to_reg_i,
  output logic        stall_o,
  output logic        branch_taken_o,
  output logic [31:0] branch_target_o,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [31:0] dmem_wdata_o,
  output logic [3:0]  dmem_be_o,
  input  logic        dmem_gnt_i,
  input  logic        dmem_rvalid_i,
  input  logic [31:0] dmem_rdata_i,
  output logic        wb_valid_o,
  output logic        wb_reg_write_o,
  output logic [31:0] wb_pc_plus_4_o,
  output logic [31:0] wb_alu_result_o,
  output logic [31:0] wb_mem_data_o,
  output logic [4:0]  wb_rd_addr_o,
  output logic [1:0]  wb_mem_to_reg_o,
  output logic        bus_err_o
`ifdef MEM_MISALIGN_TRAP_EN
  ,output logic       misalign_o
`endif
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} state_e;

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic [1:0]    lo_q;
  logic [2:0]    f3_q;

  logic        mem_op, misal, acc, cnt_last;
  logic        done, abort, load_done, req;
  logic        cond;
  logic [31:0] load_data;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  assign mem_op = valid_i & (mem_read_i | mem_write_i);

`ifdef MEM_MISALIGN_TRAP_EN
  assign misal = mem_op & (((funct3_i[1:0] == 2'b01) & ex_result_i[0]) |
                           ((funct3_i[1:0] == 2'b10) & (ex_result_i[1:0] != 2'b00)));
`else
  assign misal = 1'b0;
`endif

  assign acc      = mem_op & ~misal;
  assign cnt_last = (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  // Completion decision for the current cycle; done releases the stall.
  always_comb begin
    req       = 1'b0;
    done      = misal;
    abort     = 1'b0;
    load_done = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (acc) begin
          req = 1'b1;
          if (dmem_gnt_i & mem_write_i) done = 1'b1;
        end
      end
      S_REQ: begin
        if (acc) begin
          req = 1'b1;
          if (dmem_gnt_i & mem_write_i) begin
            done = 1'b1;
          end else if (!dmem_gnt_i && cnt_last) begin
            done  = 1'b1;
            abort = 1'b1;
          end
        end
      end
      S_RESP: begin
        if (acc) begin
          if (dmem_rvalid_i) begin
            done      = 1'b1;
            load_done = 1'b1;
          end else if (cnt_last) begin
            done  = 1'b1;
            abort = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  assign stall_o     = mem_op & ~done;
  assign dmem_req_o  = req;
  assign dmem_we_o   = req & mem_write_i;
  assign dmem_addr_o = {ex_result_i[31:2], 2'b00};

  always_comb begin
    dmem_be_o    = 4'b1111;
    dmem_wdata_o = reg2_data_i;
    case (funct3_i[1:0])
      2'b00: begin
        dmem_be_o    = 4'b0001 << ex_result_i[1:0];
        dmem_wdata_o = {4{reg2_data_i[7:0]}};
      end
      2'b01: begin
        dmem_be_o    = 4'b0011 << {ex_result_i[1], 1'b0};
        dmem_wdata_o = {2{reg2_data_i[15:0]}};
      end
      default: ;
    endcase
  end

  // Lane selection uses the offset and size captured at grant time.
  always_comb begin
    case (lo_q)
      2'd0:    ld_byte = dmem_rdata_i[7:0];
      2'd1:    ld_byte = dmem_rdata_i[15:8];
      2'd2:    ld_byte = dmem_rdata_i[23:16];
      default: ld_byte = dmem_rdata_i[31:24];
    endcase
    ld_half = lo_q[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];
    case (f3_q)
      3'b000:  load_data = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  load_data = {{16{ld_half[15]}}, ld_half};
      3'b100:  load_data = {24'd0, ld_byte};
      3'b101:  load_data = {16'd0, ld_half};
      default: load_data = dmem_rdata_i;
    endcase
  end

  always_comb begin
    case (funct3_i)
      3'b000:          cond = zero_flag_i;
      3'b001:          cond = ~zero_flag_i;
      3'b100, 3'b110:  cond = ex_result_i[0];
      3'b101, 3'b111:  cond = ~ex_result_i[0];
      default:         cond = 1'b0;
    endcase
  end

  assign branch_taken_o  = valid_i & branch_ctrl_i & cond;
  assign branch_target_o = pc_i + immediate_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      lo_q    <= 2'b00;
      f3_q    <= 3'b000;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (acc && !done) begin
            cnt_q <= '0;
            if (dmem_gnt_i) begin
              state_q <= S_RESP;
              lo_q    <= ex_result_i[1:0];
              f3_q    <= funct3_i;
            end else begin
              state_q <= S_REQ;
            end
          end
        end
        S_REQ: begin
          if (!acc || done) begin
            state_q <= S_IDLE;
          end else if (dmem_gnt_i) begin
            state_q <= S_RESP;
            cnt_q   <= '0;
            lo_q    <= ex_result_i[1:0];
            f3_q    <= funct3_i;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_RESP: begin
          if (!acc || done) state_q <= S_IDLE;
          else              cnt_q   <= cnt_q + CW'(1);
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_valid_o      <= 1'b0;
      wb_reg_write_o  <= 1'b0;
      wb_pc_plus_4_o  <= '0;
      wb_alu_result_o <= '0;
      wb_mem_data_o   <= '0;
      wb_rd_addr_o    <= '0;
      wb_mem_to_reg_o <= '0;
      bus_err_o       <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
      misalign_o      <= 1'b0;
`endif
    end else begin
      bus_err_o <= abort;
`ifdef MEM_MISALIGN_TRAP_EN
      misalign_o <= misal;
`endif
      if (!stall_o) begin
        wb_valid_o      <= valid_i;
        wb_reg_write_o  <= valid_i & reg_write_i & ~abort & ~misal;
        wb_pc_plus_4_o  <= pc_plus_4_i;
        wb_alu_result_o <= ex_result_i;
        wb_mem_data_o   <= load_done ? load_data : 32'd0;
        wb_rd_addr_o    <= rd_addr_i;
        wb_mem_to_reg_o <= mem_to_reg_i;
      end else begin
        wb_valid_o     <= 1'b0;
        wb_reg_write_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - self-checking bench for mem_stage (vector table, directed corners, random ops vs. model).
module tb_mem_stage;

  localparam int TO = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i;
  logic [31:0] pc_i, pc_plus_4_i, ex_result_i, reg2_data_i, immediate_i;
  logic        zero_flag_i;
  logic [4:0]  rd_addr_i;
  logic [2:0]  funct3_i;
  logic        mem_read_i, mem_write_i, branch_ctrl_i, reg_write_i;
  logic [1:0]  mem_to_reg_i;
  logic        stall_o, branch_taken_o;
  logic [31:0] branch_target_o;
  logic        dmem_req_o, dmem_we_o;
  logic [31:0] dmem_addr_o, dmem_wdata_o;
  logic [3:0]  dmem_be_o;
  logic        dmem_gnt_i, dmem_rvalid_i;
  logic [31:0] dmem_rdata_i;
  logic        wb_valid_o, wb_reg_write_o;
  logic [31:0] wb_pc_plus_4_o, wb_alu_result_o, wb_mem_data_o;
  logic [4:0]  wb_rd_addr_o;
  logic [1:0]  wb_mem_to_reg_o;
  logic        bus_err_o;
`ifdef MEM_MISALIGN_TRAP_EN
  logic        misalign_o;
`endif

  int n_checks = 0;
  int n_err    = 0;
  logic [31:0] last_wb_mem;

  mem_stage #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .pc_i(pc_i), .pc_plus_4_i(pc_plus_4_i),
    .ex_result_i(ex_result_i), .zero_flag_i(zero_flag_i), .reg2_data_i(reg2_data_i),
    .immediate_i(immediate_i), .rd_addr_i(rd_addr_i), .funct3_i(funct3_i),
    .mem_read_i(mem_read_i), .mem_write_i(mem_write_i), .branch_ctrl_i(branch_ctrl_i),
    .reg_write_i(reg_write_i), .mem_to_reg_i(mem_to_reg_i), .stall_o(stall_o),
    .branch_taken_o(branch_taken_o), .branch_target_o(branch_target_o),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
    .dmem_wdata_o(dmem_wdata_o), .dmem_be_o(dmem_be_o), .dmem_gnt_i(dmem_gnt_i),
    .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i),
    .wb_valid_o(wb_valid_o), .wb_reg_write_o(wb_reg_write_o),
    .wb_pc_plus_4_o(wb_pc_plus_4_o), .wb_alu_result_o(wb_alu_result_o),
    .wb_mem_data_o(wb_mem_data_o), .wb_rd_addr_o(wb_rd_addr_o),
    .wb_mem_to_reg_o(wb_mem_to_reg_o), .bus_err_o(bus_err_o)
`ifdef MEM_MISALIGN_TRAP_EN
    , .misalign_o(misalign_o)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    valid_i = 0; pc_i = 0; pc_plus_4_i = 0; ex_result_i = 0; zero_flag_i = 0;
    reg2_data_i = 0; immediate_i = 0; rd_addr_i = 0; funct3_i = 0;
    mem_read_i = 0; mem_write_i = 0; branch_ctrl_i = 0; reg_write_i = 0; mem_to_reg_i = 0;
    dmem_gnt_i = 0; dmem_rvalid_i = 0; dmem_rdata_i = 0;
  endtask

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input int lo, input logic [31:0] w);
    longint unsigned b, h;
    b = (longint'(w) >> (8 * lo)) & 255;
    h = (longint'(w) >> (16 * (lo / 2))) & 65535;
    case (f3)
      3'b000:  return (b >= 128) ? 32'(b + 64'hFFFFFF00) : 32'(b);
      3'b001:  return (h >= 32768) ? 32'(h + 64'hFFFF0000) : 32'(h);
      3'b100:  return 32'(b);
      3'b101:  return 32'(h);
      default: return w;
    endcase
  endfunction

  function automatic logic [3:0] ref_be(input logic [2:0] f3, input int lo);
    if (f3[1:0] == 2'b00) return 4'(1 << lo);
    if (f3[1:0] == 2'b01) return 4'(3 << (2 * (lo / 2)));
    return 4'hF;
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] d);
    if (f3[1:0] == 2'b00) return (d & 32'hFF) * 32'h01010101;
    if (f3[1:0] == 2'b01) return (d & 32'hFFFF) * 32'h00010001;
    return d;
  endfunction

  function automatic logic ref_taken(input logic v, input logic br, input logic [2:0] f3,
                                     input logic z, input logic [31:0] ex);
    logic lt;
    if (!(v && br)) return 1'b0;
    lt = ex[0];
    case (f3)
      3'b000: return z;
      3'b001: return !z;
      3'b100, 3'b110: return lt;
      3'b101, 3'b111: return !lt;
      default: return 1'b0;
    endcase
  endfunction

  // One memory op: gnt in cycle g, rvalid r cycles after gnt for loads. Enter/leave at posedge+1.
  task automatic do_mem(input logic is_st, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] rword, input int g, input int r,
                        input logic [4:0] rd, input logic junk_rv);
    int last;
    logic [31:0] pc;
    pc = $urandom & 32'hFFFFFFFC;
    idle_inputs();
    valid_i = 1; mem_read_i = !is_st; mem_write_i = is_st; funct3_i = f3; ex_result_i = addr;
    reg2_data_i = wd; rd_addr_i = rd; reg_write_i = !is_st; mem_to_reg_i = is_st ? 2'd0 : 2'd1;
    pc_i = pc; pc_plus_4_i = pc + 4;
    last = is_st ? g : g + r;
    for (int k = 0; k <= last; k++) begin
      dmem_gnt_i    = (k == g);
      dmem_rvalid_i = (!is_st && k == g + r) || (junk_rv && k <= g);
      dmem_rdata_i  = (k == g + r) ? rword : $urandom;
      #3;
      chk("stall", stall_o, k != last);
      chk("req", dmem_req_o, k <= g);
      if (k <= g) begin
        chk("addr", dmem_addr_o, addr & 32'hFFFFFFFC);
        chk("we", dmem_we_o, is_st);
        if (is_st) begin
          chk("be", dmem_be_o, ref_be(f3, int'(addr[1:0])));
          chk("wdata", dmem_wdata_o, ref_wdata(f3, wd));
        end
      end
      tick();
    end
    idle_inputs();
    #3;
    chk("wb_valid", wb_valid_o, 1);
    chk("wb_reg_write", wb_reg_write_o, !is_st);
    chk("wb_rd", wb_rd_addr_o, rd);
    chk("wb_pc4", wb_pc_plus_4_o, pc + 4);
    chk("wb_alu", wb_alu_result_o, addr);
    if (!is_st) chk("wb_mem", wb_mem_data_o, ref_load(f3, int'(addr[1:0]), rword));
    last_wb_mem = wb_mem_data_o;
    tick();
  endtask

  typedef struct {
    logic        v;
    logic [2:0]  f3;
    logic        z;
    logic [31:0] ex;
    logic [31:0] pc;
    logic [31:0] imm;
    logic        exp_taken;
    logic [31:0] exp_tgt;
  } br_vec_t;

  br_vec_t tbl[10];

  initial begin
    int drop;
    logic [2:0] f3;
    int lo;
    logic st;

    tbl[0] = '{1'b1, 3'b001, 1'b0, 32'h0, 32'h200, 32'hFFFFFFF8, 1'b1, 32'h1F8};
    tbl[1] = '{1'b1, 3'b000, 1'b0, 32'h0, 32'h200, 32'hFFFFFFF8, 1'b0, 32'h1F8};
    tbl[2] = '{1'b1, 3'b000, 1'b1, 32'h0, 32'h100, 32'h10, 1'b1, 32'h110};
    tbl[3] = '{1'b1, 3'b100, 1'b0, 32'h1, 32'h100, 32'h20, 1'b1, 32'h120};
    tbl[4] = '{1'b1, 3'b111, 1'b0, 32'h1, 32'h100, 32'h20, 1'b0, 32'h120};
    tbl[5] = '{1'b1, 3'b101, 1'b1, 32'h0, 32'h40, 32'h4, 1'b1, 32'h44};
    tbl[6] = '{1'b1, 3'b010, 1'b1, 32'h1, 32'h40, 32'h4, 1'b0, 32'h44};
    tbl[7] = '{1'b1, 3'b011, 1'b0, 32'h0, 32'h40, 32'h4, 1'b0, 32'h44};
    tbl[8] = '{1'b1, 3'b110, 1'b0, 32'h1, 32'hFFFFFFFC, 32'h8, 1'b1, 32'h4};
    tbl[9] = '{1'b0, 3'b000, 1'b1, 32'h0, 32'h80, 32'h8, 1'b0, 32'h88};

    rst = 1;
    idle_inputs();
    tick();
    tick();
    #3;
    chk("rst_wb_valid", wb_valid_o, 0);
    chk("rst_wb_rw", wb_reg_write_o, 0);
    chk("rst_wb_alu", wb_alu_result_o, 0);
    chk("rst_wb_mem", wb_mem_data_o, 0);
    chk("rst_bus_err", bus_err_o, 0);
    chk("rst_req", dmem_req_o, 0);
    chk("rst_stall", stall_o, 0);
    tick();
    rst = 0;

    // ADD rd=5
    valid_i = 1; reg_write_i = 1; rd_addr_i = 5; ex_result_i = 32'h1234;
    #3;
    chk("add_stall", stall_o, 0);
    chk("add_req", dmem_req_o, 0);
    tick();
    idle_inputs();
    #3;
    chk("add_wb_valid", wb_valid_o, 1);
    chk("add_wb_alu", wb_alu_result_o, 32'h1234);
    chk("add_wb_rd", wb_rd_addr_o, 5);
    chk("add_wb_rw", wb_reg_write_o, 1);
    tick();

    for (int i = 0; i < 10; i++) begin
      idle_inputs();
      valid_i = tbl[i].v; branch_ctrl_i = 1; funct3_i = tbl[i].f3; zero_flag_i = tbl[i].z;
      ex_result_i = tbl[i].ex; pc_i = tbl[i].pc; immediate_i = tbl[i].imm;
      #3;
      chk($sformatf("br_taken[%0d]", i), branch_taken_o, tbl[i].exp_taken);
      chk($sformatf("br_tgt[%0d]", i), branch_target_o, tbl[i].exp_tgt);
      chk($sformatf("br_stall[%0d]", i), stall_o, 0);
      tick();
    end

    // SB 0x103, same-cycle grant
    do_mem(1, 3'b000, 32'h103, 32'hAB, 0, 0, 0, 0, 0);
    // LB / LBU 0x102, gnt after 2 cycles, rvalid 3 after gnt
    do_mem(0, 3'b000, 32'h102, 0, 32'h00800000, 2, 3, 7, 0);
    chk("lb_result", last_wb_mem, 32'hFFFFFF80);
    do_mem(0, 3'b100, 32'h102, 0, 32'h00800000, 2, 3, 7, 0);
    chk("lbu_result", last_wb_mem, 32'h00000080);
    // rvalid together with gnt (and while waiting for gnt) must be ignored
    do_mem(0, 3'b010, 32'h200, 0, 32'hCAFEF00D, 1, 2, 9, 1);

    // Load timeout
    idle_inputs();
    valid_i = 1; mem_read_i = 1; reg_write_i = 1; rd_addr_i = 3; ex_result_i = 32'h300;
    funct3_i = 3'b010;
    drop = -1;
    for (int k = 0; k <= TO + 3; k++) begin
      dmem_gnt_i = (k == 0);
      #3;
      if (!stall_o) drop = k;
      tick();
      if (drop >= 0) break;
    end
    chk("to_cycle", 32'(drop), TO);
    idle_inputs();
    #3;
    chk("to_bus_err", bus_err_o, 1);
    chk("to_wb_valid", wb_valid_o, 1);
    chk("to_wb_rw", wb_reg_write_o, 0);
    tick();
    dmem_rvalid_i = 1; dmem_rdata_i = 32'h12345678;
    #3;
    chk("to_bus_err_end", bus_err_o, 0);
    chk("to_late_stall", stall_o, 0);
    chk("to_late_req", dmem_req_o, 0);
    tick();
    dmem_rvalid_i = 0;
    #3;
    chk("to_late_wb", wb_valid_o, 0);
    tick();
    do_mem(1, 3'b010, 32'h400, 32'h55AA33CC, 0, 0, 0, 0, 0);

    // Reset during RESP
    idle_inputs();
    valid_i = 1; mem_read_i = 1; reg_write_i = 1; ex_result_i = 32'h500; funct3_i = 3'b010;
    dmem_gnt_i = 1;
    tick();
    dmem_gnt_i = 0;
    #3;
    chk("rs_resp_stall", stall_o, 1);
    chk("rs_resp_req", dmem_req_o, 0);
    tick();
    rst = 1;
    idle_inputs();
    tick();
    rst = 0;
    #3;
    chk("rs_req", dmem_req_o, 0);
    chk("rs_wb_valid", wb_valid_o, 0);
    tick();
    dmem_rvalid_i = 1;
    #3;
    chk("rs_late_stall", stall_o, 0);
    tick();
    dmem_rvalid_i = 0;
    #3;
    chk("rs_late_wb", wb_valid_o, 0);
    tick();
    do_mem(0, 3'b001, 32'h502, 0, 32'h8001_7FFF, 0, 1, 4, 0);

`ifdef MEM_MISALIGN_TRAP_EN
    idle_inputs();
    valid_i = 1; mem_read_i = 1; reg_write_i = 1; ex_result_i = 32'h102; funct3_i = 3'b010;
    #3;
    chk("mis_req", dmem_req_o, 0);
    chk("mis_stall", stall_o, 0);
    tick();
    idle_inputs();
    #3;
    chk("mis_pulse", misalign_o, 1);
    chk("mis_wb_valid", wb_valid_o, 1);
    chk("mis_wb_rw", wb_reg_write_o, 0);
    tick();
    #3;
    chk("mis_pulse_end", misalign_o, 0);
    tick();
`else
    do_mem(0, 3'b010, 32'h102, 0, 32'h89ABCDEF, 0, 1, 2, 0);
    do_mem(1, 3'b010, 32'h103, 32'h01020304, 0, 1, 0, 0, 0);
`endif

    // Random mix against the reference model
    for (int n = 0; n < 40; n++) begin
      int kind;
      kind = $urandom_range(0, 3);
      if (kind == 0) begin
        logic [31:0] ex, pc, imm;
        logic z;
        idle_inputs();
        ex = $urandom; pc = $urandom; imm = $urandom; z = 1'($urandom);
        f3 = 3'($urandom);
        valid_i = 1; branch_ctrl_i = 1'($urandom); funct3_i = f3; zero_flag_i = z;
        ex_result_i = ex; pc_i = pc; immediate_i = imm;
        #3;
        chk("rnd_taken", branch_taken_o, ref_taken(1'b1, branch_ctrl_i, f3, z, ex));
        chk("rnd_tgt", branch_target_o, pc + imm);
        chk("rnd_nomem_stall", stall_o, 0);
        tick();
      end else begin
        st = (kind == 1);
        if (st) begin
          case ($urandom_range(0, 2))
            0: f3 = 3'b000;
            1: f3 = 3'b001;
            default: f3 = 3'b010;
          endcase
        end else begin
          case ($urandom_range(0, 4))
            0: f3 = 3'b000;
            1: f3 = 3'b001;
            2: f3 = 3'b010;
            3: f3 = 3'b100;
            default: f3 = 3'b101;
          endcase
        end
        lo = $urandom_range(0, 3);
`ifdef MEM_MISALIGN_TRAP_EN
        if (f3[1:0] == 2'b01) lo = lo & 2;
        if (f3[1:0] == 2'b10) lo = 0;
`endif
        do_mem(st, f3, ($urandom & 32'hFFFFFFFC) | 32'(lo), $urandom, $urandom,
               $urandom_range(0, 3), $urandom_range(1, 3), 5'($urandom), 1'($urandom));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
